baudgen_frac: RTL

Programmable fractional-N baud-rate generator for the UART path: a phase accumulator produces an oversample tick. A tick-phase counter derives a per-bit tick and a mid-bit sample tick from it. Runtime increment load allows baud changes without a rebuild. A resync input realigns the phase to an RX start-bit edge. It sits between the system clock and the UART TX/RX state machines and replaces the fixed-rate generator.

---
 rtl/baudgen_frac_if.sv | 33 +++
 rtl/baudgen_frac.sv | 92 +++++++++
 2 files changed

// File: rtl/baudgen_frac_if.sv
`default_nettype none
// ============================================================================
// Module      : baudgen_frac_if
// Description : Control/status bundle between the UART controller and the
//               fractional baud-rate generator.
//               master : drives en, inc_wr, inc_in, resync; observes inc_q,
//                        tick, bit_tick, mid_tick.
//               slave  : the generator side (mirror directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface baudgen_frac_if #(
  parameter int ACC_WIDTH = 16
) ();
  logic                 en;        // accumulate enable
  logic                 inc_wr;    // load strobe for inc_in
  logic [ACC_WIDTH-1:0] inc_in;    // new increment value
  logic                 resync;    // phase realign strobe
  logic [ACC_WIDTH-1:0] inc_q;     // current increment readback
  logic                 tick;      // oversample tick
  logic                 bit_tick;  // last tick of each bit period
  logic                 mid_tick;  // mid-bit sample tick

  modport master (
    output en, inc_wr, inc_in, resync,
    input  inc_q, tick, bit_tick, mid_tick
  );

  modport slave (
    input  en, inc_wr, inc_in, resync,
    output inc_q, tick, bit_tick, mid_tick
  );
endinterface
`default_nettype wire

// File: rtl/baudgen_frac.sv
`default_nettype none
// ============================================================================
// Module      : baudgen_frac
// Description : Fractional-N baud-rate generator. A phase accumulator with a
//               runtime-loadable increment produces an oversample tick from
//               its carry; a tick-phase counter marks the last tick of each
//               bit (bit_tick) and the mid-bit sample tick (mid_tick).
//               resync realigns both accumulator and phase to an RX edge.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - baudgen_frac_if.slave (en, inc_wr, inc_in, resync in;
//                      inc_q, tick, bit_tick, mid_tick out)
// Revision    : 1.0 - initial release
// ============================================================================
module baudgen_frac #(
  parameter int CLK_HZ      = 12000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int INC_DEFAULT = ((BAUD*OVERSAMPLE<<(ACC_WIDTH-4))+(CLK_HZ>>5))/(CLK_HZ>>4)
) (
  input  wire logic     clk,
  input  wire logic     rst,
  baudgen_frac_if.slave bus
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  localparam logic [PH_W-1:0]      c_PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]      c_PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [ACC_WIDTH-1:0] c_INC_RST = ACC_WIDTH'(INC_DEFAULT);

  // Bit ACC_WIDTH of the accumulator is the carry out of the last add.
  logic [ACC_WIDTH:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [PH_W-1:0]      ph_q,  ph_d;

  logic w_tick;

  assign w_tick = acc_q[ACC_WIDTH];

  // Accumulator: the carry is always dropped before the next add, so a tick
  // can never persist longer than one cycle, even while en is low.
  always_comb begin
    acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]};
    if (bus.resync) begin
      acc_d = '0;
    end else if (bus.en) begin
      acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + {1'b0, inc_q};
    end
  end

  // Tick phase counter; a resync coinciding with a tick wins and discards
  // that tick's advance.
  always_comb begin
    ph_d = ph_q;
    if (bus.resync) begin
      ph_d = '0;
    end else if (w_tick) begin
      ph_d = (ph_q == c_PH_LAST) ? '0 : ph_q + 1'b1;
    end
  end

  // A newly loaded increment is seen by the add after the load edge; the
  // add at the load edge itself still uses the previous value.
  always_comb begin
    inc_d = inc_q;
    if (bus.inc_wr) begin
      inc_d = bus.inc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ph_q  <= '0;
      inc_q <= c_INC_RST;
    end else begin
      acc_q <= acc_d;
      ph_q  <= ph_d;
      inc_q <= inc_d;
    end
  end

  // Outputs decode registers only.
  assign bus.tick     = w_tick;
  assign bus.bit_tick = w_tick & (ph_q == c_PH_LAST);
  assign bus.mid_tick = w_tick & (ph_q == c_PH_MID);
  assign bus.inc_q    = inc_q;

endmodule
`default_nettype wire
